// File: rtl/grid_clear_buffer_if.sv
// Bus between the game processor (master) and the playfield grid buffer (slave).
// The master issues cell writes and line-clear requests; the slave returns the
// flat grid image plus sequence status and line counters.
interface grid_clear_buffer_if #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int CELL_W = 3,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0]           address;
  logic [CELL_W-1:0]           in_data;
  logic                        wren;
  logic                        clr_start;
  logic [ROWS*COLS*CELL_W-1:0] out_data;
  logic                        busy;
  logic                        done;
  logic [7:0]                  lines_cleared;
  logic [15:0]                 total_lines;

  modport master (
    output address, in_data, wren, clr_start,
    input  out_data, busy, done, lines_cleared, total_lines
  );

  modport slave (
    input  address, in_data, wren, clr_start,
    output out_data, busy, done, lines_cleared, total_lines
  );
endinterface

// File: rtl/grid_clear_buffer.sv
// Playfield grid buffer with line clearing. Holds ROWS x COLS colour cells,
// exposes them flat to the renderer, accepts single-cell writes while idle and
// runs a bottom-up scan that deletes full rows and drops the rows above.
module grid_clear_buffer #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int CELL_W = 3,
  parameter int ADDR_W = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  grid_clear_buffer_if.slave   bus
);

  localparam int NCELL = ROWS * COLS;
  localparam int GW    = NCELL * CELL_W;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ADDR_W:0] NCELL_A = (ADDR_W + 1)'(NCELL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row;
  logic [GW-1:0]   r_grid;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_lines;
  logic [15:0]     r_total;

  logic [NCELL-1:0] w_nz;
  logic [ROWS-1:0]  w_full;
  logic [GW-1:0]    w_grid_next;
  logic             w_wr_en;
  logic             w_cur_full;

  // Writes land only while idle and only for addresses inside the grid.
  assign w_wr_en    = (r_state == S_IDLE) && bus.wren && ({1'b0, bus.address} < NCELL_A);
  assign w_cur_full = w_full[r_row];

  // Per-cell next value: a SHIFT pulls the cell from the row above for rows
  // 1..r (row 0 refills with empty); otherwise an idle write may replace it.
  genvar gi;
  generate
    for (gi = 0; gi < NCELL; gi++) begin : g_cell
      localparam int ROW = gi / COLS;
      logic [CELL_W-1:0] w_shift_val;

      assign w_nz[gi] = |r_grid[gi*CELL_W +: CELL_W];

      if (ROW == 0) begin : g_top
        assign w_shift_val = '0;
      end else begin : g_below
        assign w_shift_val = (RW'(ROW) <= r_row) ? r_grid[(gi-COLS)*CELL_W +: CELL_W]
                                                 : r_grid[gi*CELL_W +: CELL_W];
      end

      assign w_grid_next[gi*CELL_W +: CELL_W] =
          (r_state == S_SHIFT)                           ? w_shift_val :
          (w_wr_en && (bus.address == ADDR_W'(gi)))      ? bus.in_data :
                                                           r_grid[gi*CELL_W +: CELL_W];
    end

    // A row is full when none of its cells is empty.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign w_full[gi] = &w_nz[gi*COLS +: COLS];
    end
  endgenerate

  // Grid storage: takes the per-cell next value every cycle, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grid <= '0;
    end else begin
      r_grid <= w_grid_next;
    end
  end

  // Line-clear sequencer: scan rows bottom-up, shift on a full row and re-test
  // the same row index, pulse done once the top row has been passed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lines <= '0;
      r_total <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.clr_start) begin
            r_row   <= RW'(ROWS - 1);
            r_lines <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cur_full) begin
            r_state <= S_SHIFT;
          end else if (r_row == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row <= r_row - 1'b1;
          end
        end
        S_SHIFT: begin
          r_lines <= r_lines + 8'd1;
          if (r_total != 16'hFFFF) begin
            r_total <= r_total + 16'd1;
          end
          r_state <= S_CHECK;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data      = r_grid;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.lines_cleared = r_lines;
  assign bus.total_lines   = r_total;

endmodule

// File: tb/tb_grid_clear_buffer.sv
// Directed bench for grid_clear_buffer: a behavioural grid model predicts each
// transaction's outcome, predictions are queued at drive time and compared
// when the buffer produces its result.
module tb_grid_clear_buffer;

  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int CELL_W = 3;
  localparam int ADDR_W = 12;
  localparam int GW     = ROWS * COLS * CELL_W;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  grid_clear_buffer_if #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .ADDR_W(ADDR_W)) bus ();

  grid_clear_buffer #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string          tag;
    logic [GW-1:0]  exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  model[ROWS][COLS];
  int  total_model = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [GW-1:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [GW-1:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [GW-1:0] model_vec();
    logic [GW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(r*COLS+c)*CELL_W +: CELL_W] = CELL_W'(model[r][c]);
    return v;
  endfunction

  // Reference clear: keep non-full rows in order, packed against the bottom.
  function automatic int model_clear();
    int  tmp[ROWS][COLS];
    int  k;
    int  dst;
    bit  full;
    k   = 0;
    dst = ROWS - 1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tmp[r][c] = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (model[r][c] == 0) full = 1'b0;
      if (full) begin
        k++;
      end else begin
        for (int c = 0; c < COLS; c++) tmp[dst][c] = model[r][c];
        dst--;
      end
    end
    model = tmp;
    total_model = (total_model + k > 65535) ? 65535 : total_model + k;
    return k;
  endfunction

  task automatic do_write(input int addr, input int data);
    bus.address = ADDR_W'(addr);
    bus.in_data = CELL_W'(data);
    bus.wren    = 1'b1;
    if (addr < ROWS * COLS) model[addr / COLS][addr % COLS] = data;
    push($sformatf("write_grid_a%0d", addr), model_vec());
    tick();
    bus.wren = 1'b0;
    pop_check(bus.out_data);
    $display("write addr=%0d data=%0d", addr, data);
  endtask

  task automatic fill_row(input int row, input int data);
    for (int c = 0; c < COLS; c++) do_write(row * COLS + c, data);
  endtask

  // Runs one clear. inject_at > 0 drives a write and clr_start during that
  // sequence cycle; same_write commits a write in the clr_start cycle.
  task automatic run_clear(input string tag, input int inject_at,
                           input bit same_write, input int waddr, input int wdata);
    int k;
    int n;
    bit busy_ok;
    bus.clr_start = 1'b1;
    if (same_write) begin
      bus.address = ADDR_W'(waddr);
      bus.in_data = CELL_W'(wdata);
      bus.wren    = 1'b1;
      model[waddr / COLS][waddr % COLS] = wdata;
    end
    k = model_clear();
    push({tag, "_done_cycle"}, GW'(ROWS + 2 * k + 1));
    push({tag, "_lines"}, GW'(k));
    push({tag, "_total"}, GW'(total_model));
    push({tag, "_grid"}, model_vec());
    tick();
    bus.clr_start = 1'b0;
    bus.wren      = 1'b0;
    n       = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (n == inject_at) begin
        bus.address   = ADDR_W'(0);
        bus.in_data   = CELL_W'(7);
        bus.wren      = 1'b1;
        bus.clr_start = 1'b1;
      end
      tick();
      bus.wren      = 1'b0;
      bus.clr_start = 1'b0;
      n++;
    end
    pop_check(GW'(n));
    check({tag, "_busy_in_seq"}, GW'(busy_ok && (bus.busy === 1'b1)), GW'(1));
    pop_check(GW'(bus.lines_cleared));
    pop_check(GW'(bus.total_lines));
    pop_check(bus.out_data);
    tick();
    check({tag, "_busy_after"}, GW'(bus.busy), GW'(0));
    check({tag, "_done_after"}, GW'(bus.done), GW'(0));
    tick();
    check({tag, "_busy_idle"}, GW'(bus.busy), GW'(0));
    $display("clear %s k=%0d done_cycle=%0d lines=%0d total=%0d",
             tag, k, n, bus.lines_cleared, bus.total_lines);
  endtask

  initial begin
    bus.address   = '0;
    bus.in_data   = '0;
    bus.wren      = 1'b0;
    bus.clr_start = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = 0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_data", bus.out_data, GW'(0));
    check("rst_busy", GW'(bus.busy), GW'(0));
    check("rst_done", GW'(bus.done), GW'(0));
    check("rst_lines", GW'(bus.lines_cleared), GW'(0));
    check("rst_total", GW'(bus.total_lines), GW'(0));
    $display("reset released");

    // Writes: in range, then out of range
    do_write(12'h0C3, 4);
    check("cell_19_5", GW'(bus.out_data[585 +: 3]), GW'(4));
    do_write(200, 7);
    do_write(4095, 3);

    // No full rows
    run_clear("none", 0, 1'b0, 0, 0);

    // Single full bottom row with a cell above it
    fill_row(19, 1);
    do_write(18 * COLS + 0, 2);
    run_clear("one_row", 0, 1'b0, 0, 0);
    check("one_row_cell_19_0", GW'(bus.out_data[(19*COLS+0)*CELL_W +: CELL_W]), GW'(2));

    // Two non-adjacent full rows around a marker
    fill_row(19, 1);
    fill_row(17, 3);
    do_write(18 * COLS + 3, 5);
    run_clear("two_rows", 0, 1'b0, 0, 0);
    check("two_rows_marker_19_3", GW'(bus.out_data[(19*COLS+3)*CELL_W +: CELL_W]), GW'(5));

    // Write and clr_start while busy are both ignored
    fill_row(19, 6);
    run_clear("busy_contention", 3, 1'b0, 0, 0);

    // Write completing row 19 in the same cycle as clr_start
    for (int c = 0; c < COLS - 1; c++) do_write(19 * COLS + c, 2);
    run_clear("same_cycle", 0, 1'b1, 19 * COLS + COLS - 1, 6);

    // Reset during a SHIFT cycle
    fill_row(19, 5);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    tick();
    check("pre_rst_busy", GW'(bus.busy), GW'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = 0;
    total_model = 0;
    check("midrst_out_data", bus.out_data, GW'(0));
    check("midrst_busy", GW'(bus.busy), GW'(0));
    check("midrst_done", GW'(bus.done), GW'(0));
    check("midrst_lines", GW'(bus.lines_cleared), GW'(0));
    check("midrst_total", GW'(bus.total_lines), GW'(0));
    $display("reset applied mid-sequence");
    do_write(5, 3);
    run_clear("after_rst", 0, 1'b0, 0, 0);

    check("scoreboard_drained", GW'(sb_q.size()), GW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
